// File: rtl/xy_move_sequencer.sv
// Splits absolute (or, with XY_MOVE_SEQ_REL_EN, relative) XY moves into
// 2^s equal signed chunks plus one remainder, handshaking each with the stepper.
module xy_move_sequencer #(
    parameter int PULSE_NUM_BITS   = 8,
    parameter int POS_BITS         = 12,
    parameter int PULSE_WIDTH_BITS = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic signed [POS_BITS-1:0]         cmd_x,
    input  logic signed [POS_BITS-1:0]         cmd_y,
    input  logic        [PULSE_WIDTH_BITS-1:0] cmd_width,
`ifdef XY_MOVE_SEQ_REL_EN
    input  logic                               cmd_rel,
`endif
    output logic                               step_start,
    output logic signed [PULSE_NUM_BITS-1:0]   step_num_x,
    output logic signed [PULSE_NUM_BITS-1:0]   step_num_y,
    output logic        [PULSE_WIDTH_BITS-1:0] step_width,
    input  logic                               step_done,
    output logic signed [POS_BITS-1:0]         pos_x,
    output logic signed [POS_BITS-1:0]         pos_y,
    output logic                               busy
);

    localparam int PNB = PULSE_NUM_BITS;
    localparam int DW  = POS_BITS + 1;
    localparam int SW  = $clog2(DW + 1);
    localparam logic [DW-1:0] MAXM = DW'((1 << (PNB - 1)) - 1);

    typedef enum logic [2:0] {IDLE, SCALE, ISSUE, WAIT, REM, REM_WAIT} state_t;

    state_t                      state;
    logic                        sx, sy;
    logic [DW-1:0]               mx, my;
    logic [SW-1:0]               s;
    logic [DW-1:0]               cnt;
    logic signed [PNB-1:0]       qx, qy, rx, ry;
    logic [PULSE_WIDTH_BITS-1:0] width_q;

    logic [DW-1:0]         ext_x, ext_y, dx, dy;
    logic [DW-1:0]         shx, shy, mask, rmx, rmy;
    logic                  fits, rem_nz;
    logic signed [PNB-1:0] qx_n, qy_n, rx_n, ry_n;

    always_comb begin
        ext_x = {cmd_x[POS_BITS-1], cmd_x};
        ext_y = {cmd_y[POS_BITS-1], cmd_y};
        dx    = ext_x - {pos_x[POS_BITS-1], pos_x};
        dy    = ext_y - {pos_y[POS_BITS-1], pos_y};
`ifdef XY_MOVE_SEQ_REL_EN
        if (cmd_rel) begin
            dx = ext_x;
            dy = ext_y;
        end
`endif
        shx  = mx >> s;
        shy  = my >> s;
        mask = ~({DW{1'b1}} << s);
        rmx  = mx & mask;
        rmy  = my & mask;
        fits = (shx <= MAXM) && (shy <= MAXM);
        // sign goes on after the shift so chunks round toward zero
        qx_n = sx ? -PNB'(shx) : PNB'(shx);
        qy_n = sy ? -PNB'(shy) : PNB'(shy);
        rx_n = sx ? -PNB'(rmx) : PNB'(rmx);
        ry_n = sy ? -PNB'(rmy) : PNB'(rmy);
        rem_nz = (rx != '0) || (ry != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            step_start <= 1'b0;
            step_num_x <= '0;
            step_num_y <= '0;
            step_width <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            sx         <= 1'b0;
            sy         <= 1'b0;
            mx         <= '0;
            my         <= '0;
            s          <= '0;
            cnt        <= '0;
            qx         <= '0;
            qy         <= '0;
            rx         <= '0;
            ry         <= '0;
            width_q    <= '0;
        end else begin
            step_start <= 1'b0;
            unique case (state)
                IDLE: if (cmd_valid) begin
                    sx        <= dx[DW-1];
                    sy        <= dy[DW-1];
                    mx        <= dx[DW-1] ? -dx : dx;
                    my        <= dy[DW-1] ? -dy : dy;
                    width_q   <= cmd_width;
                    s         <= '0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= SCALE;
                end
                SCALE: if (fits) begin
                    qx  <= qx_n;
                    qy  <= qy_n;
                    rx  <= rx_n;
                    ry  <= ry_n;
                    cnt <= {{(DW-1){1'b0}}, 1'b1} << s;
                    if ((shx == '0) && (shy == '0)) begin
                        state <= REM;
                    end else begin
                        step_start <= 1'b1;
                        step_num_x <= qx_n;
                        step_num_y <= qy_n;
                        step_width <= width_q;
                        state      <= ISSUE;
                    end
                end else begin
                    s <= s + 1'b1;
                end
                ISSUE: state <= WAIT;
                WAIT: if (step_done) begin
                    pos_x <= pos_x + POS_BITS'(qx);
                    pos_y <= pos_y + POS_BITS'(qy);
                    cnt   <= cnt - 1'b1;
                    if (cnt != {{(DW-1){1'b0}}, 1'b1}) begin
                        step_start <= 1'b1;
                        state      <= ISSUE;
                    end else if (rem_nz) begin
                        // remainder chunk goes out in the REM cycle itself
                        step_start <= 1'b1;
                        step_num_x <= rx;
                        step_num_y <= ry;
                        state      <= REM;
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                REM: if (rem_nz) begin
                    state <= REM_WAIT;
                end else begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                REM_WAIT: if (step_done) begin
                    pos_x     <= pos_x + POS_BITS'(rx);
                    pos_y     <= pos_y + POS_BITS'(ry);
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xy_move_sequencer.sv
// Scoreboard bench for xy_move_sequencer: a chunking model predicts every
// step_start; a responder plays the stepper controller.
module tb_xy_move_sequencer;

    localparam int PNB = 8;
    localparam int PB  = 12;
    localparam int PWB = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic signed [PB-1:0]  cmd_x, cmd_y;
    logic [PWB-1:0]        cmd_width;
`ifdef XY_MOVE_SEQ_REL_EN
    logic                  cmd_rel;
`endif
    logic                  step_start;
    logic signed [PNB-1:0] step_num_x, step_num_y;
    logic [PWB-1:0]        step_width;
    logic                  step_done;
    logic signed [PB-1:0]  pos_x, pos_y;
    logic                  busy;

    xy_move_sequencer #(
        .PULSE_NUM_BITS(PNB),
        .POS_BITS(PB),
        .PULSE_WIDTH_BITS(PWB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x(cmd_x),
        .cmd_y(cmd_y),
        .cmd_width(cmd_width),
`ifdef XY_MOVE_SEQ_REL_EN
        .cmd_rel(cmd_rel),
`endif
        .step_start(step_start),
        .step_num_x(step_num_x),
        .step_num_y(step_num_y),
        .step_width(step_width),
        .step_done(step_done),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int w;
        int at;
    } chunk_t;

    chunk_t sb[$];
    chunk_t mon_e;
    int vectors = 0;
    int miscompares = 0;
    int mpx = 0;
    int mpy = 0;
    int done_cyc = 0;
    int resp_starts = 0;
    int stall_on = -1;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(int v);
        logic signed [PB-1:0] t;
        t = v[PB-1:0];
        return int'(t);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: smallest s with both |d|>>s within 127, 2^s truncated
    // quotients, then the exact leftover as one extra chunk.
    task automatic model_cmd(input int tx, input int ty, input bit rel,
                             input int w, input int a, output bit zero);
        int dx, dy, s, n, qx, qy, rx, ry;
        chunk_t e;
        dx = rel ? tx : tx - mpx;
        dy = rel ? ty : ty - mpy;
        s  = 0;
        while ((iabs(dx) >> s) > 127 || (iabs(dy) >> s) > 127) s++;
        n  = 1 << s;
        qx = dx / n;
        qy = dy / n;
        rx = dx - qx * n;
        ry = dy - qy * n;
        if (qx != 0 || qy != 0) begin
            for (int i = 0; i < n; i++) begin
                e = '{qx, qy, w, (i == 0) ? a + s + 2 : -1};
                sb.push_back(e);
            end
        end
        if (rx != 0 || ry != 0) begin
            e = '{rx, ry, w, -1};
            sb.push_back(e);
        end
        mpx  = wrap(mpx + dx);
        mpy  = wrap(mpy + dy);
        zero = (dx == 0) && (dy == 0);
    endtask

    task automatic issue_cmd(input int tx, input int ty, input bit rel,
                             output int a, output bit zero);
        int w;
        w = int'($urandom_range(65535));
        a = cyc;
        model_cmd(tx, ty, rel, w, a, zero);
        cmd_x     = tx[PB-1:0];
        cmd_y     = ty[PB-1:0];
        cmd_width = w[PWB-1:0];
`ifdef XY_MOVE_SEQ_REL_EN
        cmd_rel   = rel;
`endif
        cmd_valid = 1'b1;
        chk("accept_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int a, input bit zero);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_timeout", int'(got), 1);
        chk("ready_cycle", cyc, zero ? a + 3 : done_cyc + 1);
        chk("pos_x", int'(pos_x), mpx);
        chk("pos_y", int'(pos_y), mpy);
        chk("busy_idle", int'(busy), 0);
        chk("chunks_left", sb.size(), 0);
    endtask

    task automatic do_cmd(input int tx, input int ty, input bit rel);
        int a;
        bit zero;
        issue_cmd(tx, ty, rel, a, zero);
        finish_cmd(a, zero);
    endtask

    always @(negedge clk) begin
        if (!reset && step_start) begin
            if (sb.size() == 0) begin
                chk("unexpected_chunk", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("chunk_x", int'(step_num_x), mon_e.x);
                chk("chunk_y", int'(step_num_y), mon_e.y);
                chk("chunk_width", int'(step_width), mon_e.w);
                chk("chunk_cycle", cyc,
                    (mon_e.at >= 0) ? mon_e.at : done_cyc + 1);
            end
        end
    end

    // Stepper controller stand-in, sometimes with a done that coincides
    // with step_start and must be ignored.
    initial begin
        step_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && step_start) begin
                resp_starts++;
                if (resp_starts != stall_on) begin
                    if ($urandom_range(3) == 0) step_done = 1'b1;
                    @(posedge clk);
                    #1 step_done = 1'b0;
                    repeat (1 + $urandom_range(2)) @(negedge clk);
                    step_done = 1'b1;
                    done_cyc  = cyc;
                    @(posedge clk);
                    #1 step_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        bit zero, got, rel;
        int tx, ty, m;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_width = '0;
`ifdef XY_MOVE_SEQ_REL_EN
        cmd_rel   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_start", int'(step_start), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_num_x", int'(step_num_x), 0);
        chk("rst_width", int'(step_width), 0);
        reset = 1'b0;
        @(negedge clk);

        do_cmd(100, -50, 1'b0);
        do_cmd(1000, 300, 1'b0);
        do_cmd(1000, 300, 1'b0);
        do_cmd(0, 0, 1'b0);

        // stall the third chunk of a long move, then reset in WAIT
        stall_on = resp_starts + 3;
        issue_cmd(1000, 300, 1'b0, a, zero);
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (resp_starts == stall_on) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("stall_reached", int'(got), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_step_start", int'(step_start), 0);
        chk("midrst_cmd_ready", int'(cmd_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pos_x", int'(pos_x), 0);
        chk("midrst_pos_y", int'(pos_y), 0);
        sb.delete();
        mpx = 0;
        mpy = 0;
        @(negedge clk);
        reset    = 1'b0;
        stall_on = -1;
        @(negedge clk);
        do_cmd(5, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rel = 1'b0;
`ifdef XY_MOVE_SEQ_REL_EN
            rel = 1'($urandom_range(1));
`endif
            m = int'($urandom_range(3));
            if (m <= 1) begin
                tx = int'($urandom_range(4095)) - 2048;
                ty = int'($urandom_range(4095)) - 2048;
            end else if (m == 2) begin
                tx = int'($urandom_range(300)) - 150;
                ty = int'($urandom_range(300)) - 150;
                if (!rel) begin
                    tx = tx + mpx;
                    ty = ty + mpy;
                    if (tx > 2047) tx = 2047;
                    if (tx < -2048) tx = -2048;
                    if (ty > 2047) ty = 2047;
                    if (ty < -2048) ty = -2048;
                end
            end else begin
                tx = rel ? 0 : mpx;
                ty = rel ? 0 : mpy;
            end
            do_cmd(tx, ty, rel);
        end

`ifdef XY_MOVE_SEQ_REL_EN
        do_cmd(1000, 300, 1'b0);
        do_cmd(-10, 5, 1'b1);
        chk("rel_pos_x", int'(pos_x), 990);
        chk("rel_pos_y", int'(pos_y), 305);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
